// File: rtl/mod_74x165_tx.sv
// rtl/mod_74x165_tx.sv - 74x165-style parallel-in serial-out frame transmitter
//
// Loads a WIDTH-bit word on a LOAD/READY handshake and shifts it out MSB
// first on QH, with QH_N as its registered complement. The line idles high.
// DONE pulses for one cycle after the last bit of a frame. A LOAD seen in
// the DONE cycle starts the next frame immediately, so frames can run
// back-to-back with a single idle-high separator bit.
//
// Optional feature, enabled by defining MOD_74X165_TX_PARITY_EN:
//   an even-parity bit (XOR of the loaded word) is appended after bit 0,
//   which delays DONE by one bit time.
//
// Parameters:
//   WIDTH  data bits per frame (2..16)
//
// Ports:
//   CLK    in   rising-edge clock
//   RST    in   synchronous reset, active-high, overrides all other inputs
//   D      in   parallel data, bit WIDTH-1 is transmitted first
//   LOAD   in   load request, taken only while READY is high
//   INH    in   clock inhibit, freezes a frame in progress while high
//   READY  out  a LOAD on this cycle will be accepted
//   BUSY   out  a frame is being transmitted
//   QH     out  serial data, idles high
//   QH_N   out  complement of QH
//   DONE   out  one-cycle pulse after the final frame bit

module mod_74x165_tx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  input  logic             INH,
  output logic             READY,
  output logic             BUSY,
  output logic             QH,
  output logic             QH_N,
  output logic             DONE
);

  // Wide enough to hold WIDTH itself, so the counter cannot wrap in a frame.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef MOD_74X165_TX_PARITY_EN
    S_PAR   = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
`ifdef MOD_74X165_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic ready_q, ready_d;
  logic busy_q,  busy_d;
  logic qh_q,    qh_d;
  logic qh_n_q;
  logic done_q,  done_d;

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
`ifdef MOD_74X165_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      // IDLE and DONE both present READY=1, so both accept a load. INH is
      // deliberately ignored here; it only freezes a frame already running.
      S_IDLE, S_DONE: begin
        if (LOAD) begin
          state_d  = S_SHIFT;
          shift_d  = D;
          count_d  = '0;
`ifdef MOD_74X165_TX_PARITY_EN
          parity_d = ^D;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        if (!INH) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
`ifdef MOD_74X165_TX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_DONE;
`endif
          end
        end
      end

`ifdef MOD_74X165_TX_PARITY_EN
      S_PAR: begin
        if (!INH) begin
          state_d = S_DONE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they can be registered
  // and still line up with the state they describe.
  always_comb begin
    ready_d = 1'b1;
    busy_d  = 1'b0;
    qh_d    = 1'b1;
    done_d  = 1'b0;

    case (state_d)
      S_SHIFT: begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
        qh_d    = shift_d[WIDTH-1];
      end
`ifdef MOD_74X165_TX_PARITY_EN
      S_PAR: begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
        qh_d    = parity_d;
      end
`endif
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      count_q  <= '0;
`ifdef MOD_74X165_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      qh_q     <= 1'b1;
      qh_n_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
`ifdef MOD_74X165_TX_PARITY_EN
      parity_q <= parity_d;
`endif
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      qh_q     <= qh_d;
      // Separate flop rather than an inverter so QH_N is a true register
      // output that is guaranteed complementary to QH on every cycle.
      qh_n_q   <= ~qh_d;
      done_q   <= done_d;
    end
  end

  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign QH    = qh_q;
  assign QH_N  = qh_n_q;
  assign DONE  = done_q;

endmodule

// File: doc/mod_74x165_tx.md
Name: mod_74x165_tx

Overview:
- Parallel-in, serial-out frame transmitter modelled on the 74x165 shift register, plus a load handshake and frame sequencing.
- It is the transmit end of the serial links whose receive side uses the SIPO parts (74x164-style) in the library.
- It provides true and complemented serial outputs (QH, QH_N), so downstream inverter stages such as the 74x04 modules can be checked against it.
- It sits between a parallel source and a serial line.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..16).

Ports:
- CLK    input   1      rising-edge clock
- RST    input   1      synchronous reset, active-high
- D      input   WIDTH  parallel data; bit WIDTH-1 is sent first
- LOAD   input   1      load request; accepted only when READY=1
- INH    input   1      clock inhibit; freezes shifting while high
- READY  output  1      transmitter can accept LOAD this cycle
- BUSY   output  1      frame in progress
- QH     output  1      serial data out; line idles high
- QH_N   output  1      complement of QH, always
- DONE   output  1      single-cycle pulse after the last frame bit

Behaviour:
- One clock (CLK). RST is synchronous and active-high, sampled on the rising edge of CLK.
- Reset values: state=IDLE, shift reg=0, count=0, READY=1, BUSY=0, QH=1, QH_N=0, DONE=0.
- RST has priority over every other input. Asserting it mid-frame aborts the frame: reset values appear after the edge, no DONE pulse is produced, and any partial frame is discarded.
- All outputs are registered. QH_N == ~QH in every cycle, including during reset.
- FSM states: IDLE, SHIFT, PAR (PAR exists only with the optional feature), DONE.
- IDLE:
  - READY=1, BUSY=0, QH=1.
  - On LOAD=1 at the edge: capture D into the shift reg, count=0, go to SHIFT.
  - LOAD=0: stay in IDLE.
- SHIFT:
  - READY=0, BUSY=1. QH = shift reg[WIDTH-1].
  - At each edge with INH=0: shift left by one (zero fill) and increment count.
  - When count==WIDTH-1 and INH=0: go to DONE, or to PAR if the feature is enabled.
  - INH=1: shift reg, count, state and QH all hold. Inhibit can stretch any bit by any number of cycles.
- DONE:
  - Lasts one cycle. DONE=1, QH=1, READY=1, BUSY=0.
  - LOAD=1 in this cycle is accepted, giving back-to-back frames with one idle-high separator cycle; the next state is SHIFT.
  - Otherwise the next state is IDLE.
- Latency with INH=0: LOAD accepted at edge n gives bit WIDTH-1 on QH from edge n to n+1, bit 0 from edge n+WIDTH-1, and DONE=1 from edge n+WIDTH for one cycle.
- LOAD while READY=0 is ignored and has no side effects. D is sampled only on the accepting edge; later changes to D do not affect the frame.
- LOAD and INH high together in IDLE or DONE: the load is accepted. INH takes effect from SHIFT onward.
- The count register is ceil(log2(WIDTH+1)) bits wide and never wraps inside a frame.

Optional Feature:
- Macro: MOD_74X165_TX_PARITY_EN.
- Defined:
  - After bit 0, the FSM enters PAR for one bit time, which INH can stretch.
  - In PAR, QH = even parity (XOR) of the captured D.
  - DONE follows PAR, so it arrives one cycle later: edge n+WIDTH+1.
  - A parity register is computed at the load edge.
- Undefined:
  - The PAR state, the parity register and the extra cycle do not exist; SHIFT goes directly to DONE.

Test Plan:
1. RST=1 for 2 cycles with LOAD=1 and D=8'hFF -> READY=1, BUSY=0, QH=1, QH_N=0, DONE=0. No frame starts.
2. D=8'hA5, LOAD pulse at edge n, INH=0 -> QH over 8 cycles = 1,0,1,0,0,1,0,1 and QH_N the inverse. DONE=1 only in cycle n+8 (n+9 with parity, PAR bit=0).
3. D=8'h3C, then INH=1 for 3 cycles during bit 5 -> bit 5 (value 1) is held for 4 cycles total; DONE is delayed by exactly 3 cycles.
4. LOAD=1 with D=8'h81 while BUSY=1 during a frame of D=8'h0F -> the second load is ignored and QH carries only 0,0,0,0,1,1,1,1. LOAD=1 with D=8'h81 held through DONE -> the 8'h81 frame starts immediately after the single idle-high cycle.
5. RST=1 at bit 3 of frame 8'hF0 -> next cycle shows QH=1, READY=1, BUSY=0, DONE=0. A new LOAD of 8'h01 then transmits 0,0,0,0,0,0,0,1 correctly.
6. WIDTH=4, D=4'b1100 -> QH = 1,1,0,0 and DONE at edge n+4. With parity enabled, the PAR bit is 0 and DONE arrives at n+5.
